// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU: owns a 4x8 register file, issues
// register-register instructions to the ALU and returns result plus {C,N,Z} flags.
module alu_issue_ctrl #(
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [2:0] rsp_flags
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

    localparam logic [3:0] OpNeg = 4'h9;
    localparam logic [3:0] OpAdd = 4'h6;
    localparam logic [3:0] OpSub = 4'h7;
    localparam logic [3:0] OpInc = 4'hA;
    localparam logic [3:0] OpDec = 4'hB;

    state_t     state;
    logic [7:0] regs [4];
    logic [1:0] rd;
    logic [8:0] sum;
    logic       carry;

    assign instr_ready = (state == StIdle);
    assign dbg_data    = regs[dbg_addr];

    // Carry is derived from the latched operands, not from the ALU result.
    always_comb begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        carry = 1'b0;
        case (alu_op)
            OpAdd:   carry = sum[8];
            OpSub:   carry = (alu_a < alu_b);
            OpInc:   carry = (alu_a == 8'hFF);
            OpDec:   carry = (alu_a == 8'h00);
            OpNeg:   carry = (alu_a != 8'h00);
            default: carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_RESET;
            end
            rd         <= 2'd0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_op     <= 4'h0;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'h00;
            rsp_flags  <= 3'b000;
        end else begin
            case (state)
                StIdle: begin
                    // Operands read pre-load values when load and accept coincide.
                    if (ld_en) begin
                        regs[ld_addr] <= ld_data;
                    end
                    if (instr_valid) begin
                        alu_a  <= regs[instr[3:2]];
                        alu_b  <= regs[instr[1:0]];
                        alu_op <= instr[7:4];
                        rd     <= instr[3:2];
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    regs[rd]   <= alu_c;
                    rsp_result <= alu_c;
                    rsp_flags  <= {carry, alu_c[7], (alu_c == 8'h00)};
                    rsp_valid  <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized
// instructions checked against a register-array reference model.
module tb_alu_issue_ctrl;

    localparam logic [7:0] RST_VAL = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_regs [4];
    logic [3:0] p_op;
    logic [7:0] p_a;
    logic [7:0] p_b;
    logic [1:0] p_rd;

    alu_issue_ctrl #(.REG_RESET(RST_VAL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; opcodes 4,6,7,9,A,B match the documented ones.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        logic [7:0] m;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return ~a;
            4'h3: return b;
            4'h4: return a ^ b;
            4'h5: return a << 1;
            4'h6: return a + b;
            4'h7: return a - b;
            4'h8: begin
                for (int i = 0; i < 8; i++) m[i] = a[7-i];
                return m;
            end
            4'h9: return 8'h00 - a;
            4'hA: return a + 8'h01;
            4'hB: return a - 8'h01;
            4'hC: return a >> 1;
            4'hD: return a & 8'h0F;
            4'hE: return a;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_c = alu_f(alu_op, alu_a, alu_b);

    function automatic logic [2:0] exp_flags(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] res);
        int ai = int'(a);
        int bi = int'(b);
        logic c;
        if (op == 4'h6)      c = (ai + bi) > 255;
        else if (op == 4'h7) c = ai < bi;
        else if (op == 4'hA) c = ai == 255;
        else if (op == 4'hB) c = ai == 0;
        else if (op == 4'h9) c = ai != 0;
        else                 c = 1'b0;
        return {c, res[7], res == 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(tag, dbg_data, ref_regs[i]);
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        ref_regs[a] = d;
    endtask

    // Accept edge plus checks of the issued operands; leaves a junk load active in ISSUE.
    task automatic accept(input logic [7:0] ins, input logic lden, input logic [1:0] la,
                          input logic [7:0] ldd);
        logic [31:0] r;
        chk("ready_idle", {7'b0, instr_ready}, 8'h01);
        p_op = ins[7:4];
        p_rd = ins[3:2];
        p_a  = ref_regs[ins[3:2]];
        p_b  = ref_regs[ins[1:0]];
        instr_valid = 1'b1;
        instr       = ins;
        ld_en       = lden;
        ld_addr     = la;
        ld_data     = ldd;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (lden) ref_regs[la] = ldd;
        r = $urandom;
        ld_en   = r[0];
        ld_addr = r[2:1];
        ld_data = r[15:8];
        chk("issue_a", alu_a, p_a);
        chk("issue_b", alu_b, p_b);
        chk("issue_op", {4'b0, alu_op}, {4'b0, p_op});
        chk("issue_ready", {7'b0, instr_ready}, 8'h00);
        chk("issue_rspv", {7'b0, rsp_valid}, 8'h00);
    endtask

    task automatic finish_resp(input int hold);
        logic [7:0] res;
        logic [2:0] fl;
        @(posedge clk);
        #1;
        res = alu_f(p_op, p_a, p_b);
        fl  = exp_flags(p_op, p_a, p_b, res);
        ref_regs[p_rd] = res;
        chk("resp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("resp_result", rsp_result, res);
        chk("resp_flags", {5'b0, rsp_flags}, {5'b0, fl});
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_valid", {7'b0, rsp_valid}, 8'h01);
            chk("hold_result", rsp_result, res);
            chk("hold_flags", {5'b0, rsp_flags}, {5'b0, fl});
            chk("hold_ready", {7'b0, instr_ready}, 8'h00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        chk("done_valid", {7'b0, rsp_valid}, 8'h00);
        chk("done_ready", {7'b0, instr_ready}, 8'h01);
        check_regs("regs");
    endtask

    initial begin
        logic [31:0] r;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        ld_en       = 1'b0;
        ld_addr     = 2'd0;
        ld_data     = 8'h00;
        dbg_addr    = 2'd0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < 4; i++) ref_regs[i] = RST_VAL;
        #12;
        chk("rst_a", alu_a, 8'h00);
        chk("rst_b", alu_b, 8'h00);
        chk("rst_op", {4'b0, alu_op}, 8'h00);
        chk("rst_rspv", {7'b0, rsp_valid}, 8'h00);
        chk("rst_result", rsp_result, 8'h00);
        chk("rst_flags", {5'b0, rsp_flags}, 8'h00);
        chk("rst_ready", {7'b0, instr_ready}, 8'h01);
        check_regs("rst_regs");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ADD without carry
        load(2'd0, 8'h0F);
        load(2'd1, 8'h01);
        accept(8'h61, 1'b0, 2'd0, 8'h00);
        chk("t1_a", alu_a, 8'h0F);
        finish_resp(0);
        chk("t1_r0", ref_regs[0], 8'h10);

        // 2: ADD with carry-out and zero result
        load(2'd0, 8'hFF);
        accept(8'h61, 1'b0, 2'd0, 8'h00);
        finish_resp(1);
        chk("t2_flags", {5'b0, rsp_flags}, 8'h05);

        // 3: SUB with borrow
        load(2'd2, 8'h03);
        load(2'd3, 8'h05);
        accept(8'h7B, 1'b0, 2'd0, 8'h00);
        finish_resp(0);
        chk("t3_flags", {5'b0, rsp_flags}, 8'h06);

        // 4: stalled response with a pending instruction offered throughout
        accept(8'hA0, 1'b0, 2'd0, 8'h00);
        instr_valid = 1'b1;
        instr       = 8'h65;
        finish_resp(5);
        accept(8'h65, 1'b0, 2'd0, 8'h00);
        finish_resp(0);

        // 5: load coinciding with accept
        load(2'd0, 8'h01);
        load(2'd1, 8'h10);
        accept(8'h41, 1'b1, 2'd1, 8'h20);
        chk("t5_b", alu_b, 8'h10);
        finish_resp(0);
        chk("t5_res", rsp_result, 8'h11);

        // 6: reset during ISSUE aborts the instruction
        load(2'd0, 8'h0F);
        load(2'd1, 8'h01);
        accept(8'h61, 1'b0, 2'd0, 8'h00);
        ld_en = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) ref_regs[i] = RST_VAL;
        #1;
        chk("t6_rspv", {7'b0, rsp_valid}, 8'h00);
        chk("t6_ready", {7'b0, instr_ready}, 8'h01);
        chk("t6_a", alu_a, 8'h00);
        #3;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t6_post_rspv", {7'b0, rsp_valid}, 8'h00);
        end
        check_regs("t6_regs");

        // Randomized instructions against the reference model
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            accept(r[7:0], (r[9:8] == 2'b00), r[11:10], r[23:16]);
            finish_resp(int'(r[31:30]) % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
